// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-control types: FSM states, NOP encoding and the per-stage
// enable/flush bundle consumed by the pipeline registers.
package pipe_ctrl_pkg;

   typedef enum logic {RUN, LOAD_STALL} state_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

   typedef struct packed {
      logic pc_wen;
      logic if_id_wen;
      logic if_id_flush;
      logic id_ex_wen;
      logic id_ex_flush;
      logic ex_mem_wen;
      logic mem_wb_flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_DEFAULT = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b0,
                                            id_ex_wen: 1'b1, id_ex_flush: 1'b0, ex_mem_wen: 1'b1,
                                            mem_wb_flush: 1'b0};
   localparam stage_ctrl_t CTRL_RESET   = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b1,
                                            id_ex_wen: 1'b0, id_ex_flush: 1'b1, ex_mem_wen: 1'b0,
                                            mem_wb_flush: 1'b1};
   localparam stage_ctrl_t CTRL_FREEZE  = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0,
                                            id_ex_wen: 1'b0, id_ex_flush: 1'b0, ex_mem_wen: 1'b0,
                                            mem_wb_flush: 1'b1};
   localparam stage_ctrl_t CTRL_BRANCH  = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b1,
                                            id_ex_wen: 1'b1, id_ex_flush: 1'b1, ex_mem_wen: 1'b1,
                                            mem_wb_flush: 1'b0};
   localparam stage_ctrl_t CTRL_BUBBLE  = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0,
                                            id_ex_wen: 1'b1, id_ex_flush: 1'b1, ex_mem_wen: 1'b1,
                                            mem_wb_flush: 1'b0};

   // Load in EX writes a register the ID instruction actually reads; x0 never hazards.
   function automatic logic load_use_hit(input logic mem_read, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic rs1_used, input logic rs2_used);
      return mem_read && (rd != 5'd0) &&
             ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline (master) and the
// stage enables, flushes and status returned by the controller (slave).
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ID_EX_MemRead;
   logic [4:0]       Rd_ID_EX;
   logic [4:0]       Rs1_IF_ID;
   logic [4:0]       Rs2_IF_ID;
   logic             Rs1_Used;
   logic             Rs2_Used;
   logic             Branch_Taken;
   logic             Dmem_Busy;
   logic             PC_WEN;
   logic             IF_ID_WEN;
   logic             IF_ID_Flush;
   logic             ID_EX_WEN;
   logic             ID_EX_Flush;
   logic             EX_MEM_WEN;
   logic             MEM_WB_Flush;
   logic             Mem_Timeout;
   logic [CNT_W-1:0] Stall_Cnt;
   logic [CNT_W-1:0] Flush_Cnt;

   modport master (
      output ID_EX_MemRead, Rd_ID_EX, Rs1_IF_ID, Rs2_IF_ID, Rs1_Used, Rs2_Used,
             Branch_Taken, Dmem_Busy,
      input  PC_WEN, IF_ID_WEN, IF_ID_Flush, ID_EX_WEN, ID_EX_Flush, EX_MEM_WEN,
             MEM_WB_Flush, Mem_Timeout, Stall_Cnt, Flush_Cnt
   );

   modport slave (
      input  ID_EX_MemRead, Rd_ID_EX, Rs1_IF_ID, Rs2_IF_ID, Rs1_Used, Rs2_Used,
             Branch_Taken, Dmem_Busy,
      output PC_WEN, IF_ID_WEN, IF_ID_Flush, ID_EX_WEN, ID_EX_Flush, EX_MEM_WEN,
             MEM_WB_Flush, Mem_Timeout, Stall_Cnt, Flush_Cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: memory freeze, taken-branch
// flush and multi-bubble load-use stalls, plus timeout flag and perf counters.
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_LAT    = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
)(
   input logic                clk,
   input logic                rst,
   hazard_stall_ctrl_if.slave bus
);
   // Bubble counter only needs to hold LOAD_LAT-1 (the first bubble is issued from RUN).
   localparam int BUB_W  = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(MEM_TIMEOUT);

   state_e             state, state_n;
   logic [BUB_W-1:0]   bub, bub_n;
   logic [BUSY_W-1:0]  busy_cnt, busy_inc;
   logic               timeout;
   logic               lu;
   stage_ctrl_t        ctrl;

   assign lu = load_use_hit(bus.ID_EX_MemRead, bus.Rd_ID_EX, bus.Rs1_IF_ID, bus.Rs2_IF_ID,
                            bus.Rs1_Used, bus.Rs2_Used);

   always_comb begin
      ctrl    = CTRL_DEFAULT;
      state_n = state;
      bub_n   = bub;
      if (rst) begin
         ctrl = CTRL_RESET;
      end else if (bus.Dmem_Busy) begin
         ctrl = CTRL_FREEZE;
      end else if (bus.Branch_Taken) begin
         ctrl    = CTRL_BRANCH;
         state_n = RUN;
         bub_n   = '0;
      end else if (state == LOAD_STALL) begin
         ctrl  = CTRL_BUBBLE;
         bub_n = bub - 1'b1;
         if (bub == BUB_W'(1))
            state_n = RUN;
      end else if (lu) begin
         ctrl = CTRL_BUBBLE;
         if (LOAD_LAT > 1) begin
            state_n = LOAD_STALL;
            bub_n   = BUB_W'(LOAD_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         bub   <= '0;
      end else begin
         state <= state_n;
         bub   <= bub_n;
      end
   end

   assign busy_inc = (busy_cnt == BUSY_MAX) ? busy_cnt : busy_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt <= '0;
         timeout  <= 1'b0;
      end else if (bus.Dmem_Busy) begin
         busy_cnt <= busy_inc;
         if (busy_inc == BUSY_MAX)
            timeout <= 1'b1;
      end else begin
         busy_cnt <= '0;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (!ctrl.pc_wen),
      .cnt   (bus.Stall_Cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (!bus.Dmem_Busy && bus.Branch_Taken),
      .cnt   (bus.Flush_Cnt)
   );

   assign bus.PC_WEN       = ctrl.pc_wen;
   assign bus.IF_ID_WEN    = ctrl.if_id_wen;
   assign bus.IF_ID_Flush  = ctrl.if_id_flush;
   assign bus.ID_EX_WEN    = ctrl.id_ex_wen;
   assign bus.ID_EX_Flush  = ctrl.id_ex_flush;
   assign bus.EX_MEM_WEN   = ctrl.ex_mem_wen;
   assign bus.MEM_WB_Flush = ctrl.mem_wb_flush;
   assign bus.Mem_Timeout  = timeout;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=3/MEM_TIMEOUT=8/CNT_W=16 and
// LOAD_LAT=1/MEM_TIMEOUT=1/CNT_W=3) driven in lockstep and checked against a cycle model.
module tb_hazard_stall_ctrl;

   typedef struct {
      logic       mr;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br, busy;
   } in_t;

   typedef struct {
      in_t        v;
      logic [6:0] exp;
   } vec_t;

   // Model state: bubbles still owed after this cycle, consecutive busy cycles, etc.
   typedef struct {
      int lat, lim, cmax;
      int bub, busy, stall, flush;
      bit tmo;
   } mdl_t;

   // Output packing: {PC_WEN, IF_ID_WEN, IF_ID_Flush, ID_EX_WEN, ID_EX_Flush, EX_MEM_WEN, MEM_WB_Flush}
   localparam logic [6:0] O_RST = 7'b0010101;
   localparam logic [6:0] O_FRZ = 7'b0000001;
   localparam logic [6:0] O_BR  = 7'b1111110;
   localparam logic [6:0] O_STL = 7'b0001110;
   localparam logic [6:0] O_DEF = 7'b1101010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  cur;
   int   checks = 0;
   int   fails  = 0;
   mdl_t ma, mb;

   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(16)) ia ();
   hazard_stall_ctrl_if #(.CNT_W(3))  ib ();

   assign ia.ID_EX_MemRead = cur.mr;   assign ib.ID_EX_MemRead = cur.mr;
   assign ia.Rd_ID_EX      = cur.rd;   assign ib.Rd_ID_EX      = cur.rd;
   assign ia.Rs1_IF_ID     = cur.rs1;  assign ib.Rs1_IF_ID     = cur.rs1;
   assign ia.Rs2_IF_ID     = cur.rs2;  assign ib.Rs2_IF_ID     = cur.rs2;
   assign ia.Rs1_Used      = cur.u1;   assign ib.Rs1_Used      = cur.u1;
   assign ia.Rs2_Used      = cur.u2;   assign ib.Rs2_Used      = cur.u2;
   assign ia.Branch_Taken  = cur.br;   assign ib.Branch_Taken  = cur.br;
   assign ia.Dmem_Busy     = cur.busy; assign ib.Dmem_Busy     = cur.busy;

   hazard_stall_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut_a (
      .clk (clk), .rst (rst), .bus (ia.slave)
   );
   hazard_stall_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(1), .CNT_W(3)) dut_b (
      .clk (clk), .rst (rst), .bus (ib.slave)
   );

   function automatic logic [6:0] outs_a();
      return {ia.PC_WEN, ia.IF_ID_WEN, ia.IF_ID_Flush, ia.ID_EX_WEN, ia.ID_EX_Flush,
              ia.EX_MEM_WEN, ia.MEM_WB_Flush};
   endfunction

   function automatic logic [6:0] outs_b();
      return {ib.PC_WEN, ib.IF_ID_WEN, ib.IF_ID_Flush, ib.ID_EX_WEN, ib.ID_EX_Flush,
              ib.EX_MEM_WEN, ib.MEM_WB_Flush};
   endfunction

   function automatic in_t mk(input logic mr, input int rd, input int rs1, input int rs2,
                              input logic u1, input logic u2, input logic br, input logic busy);
      in_t v;
      v.mr = mr; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.u1 = u1; v.u2 = u2; v.br = br; v.busy = busy;
      return v;
   endfunction

   function automatic bit hit(input in_t v);
      return v.mr && v.rd != 0 && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
   endfunction

   function automatic logic [6:0] mpred(input mdl_t m, input in_t v, input logic r);
      if (r)                     return O_RST;
      if (v.busy)                return O_FRZ;
      if (v.br)                  return O_BR;
      if (m.bub > 0 || hit(v))   return O_STL;
      return O_DEF;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input in_t v, input logic r);
      mdl_t n = m;
      logic [6:0] o = mpred(m, v, r);
      if (r) begin
         n.bub = 0; n.busy = 0; n.tmo = 0; n.stall = 0; n.flush = 0;
         return n;
      end
      if (v.busy) begin
         n.busy = (m.busy + 1 > m.lim) ? m.lim : m.busy + 1;
         if (n.busy == m.lim) n.tmo = 1;
      end else begin
         n.busy = 0;
         if (v.br)            n.bub = 0;
         else if (m.bub > 0)  n.bub = m.bub - 1;
         else if (hit(v))     n.bub = m.lat - 1;
         if (v.br) n.flush = (m.flush < m.cmax) ? m.flush + 1 : m.cmax;
      end
      if (!o[6]) n.stall = (m.stall < m.cmax) ? m.stall + 1 : m.cmax;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Called just after a falling edge; leaves the bench just after the next falling edge.
   task automatic apply(input in_t v, input logic r, input bit tbl, input logic [6:0] texp);
      cur = v;
      rst = r;
      #2;
      chk("ctrl_a", 32'(outs_a()), 32'(mpred(ma, v, r)));
      chk("ctrl_b", 32'(outs_b()), 32'(mpred(mb, v, r)));
      if (tbl) chk("table_b", 32'(outs_b()), 32'(texp));
      @(posedge clk);
      ma = mstep(ma, v, r);
      mb = mstep(mb, v, r);
      #1;
      chk("stall_cnt_a", 32'(ia.Stall_Cnt), 32'(ma.stall));
      chk("flush_cnt_a", 32'(ia.Flush_Cnt), 32'(ma.flush));
      chk("timeout_a",   32'(ia.Mem_Timeout), 32'(ma.tmo));
      chk("stall_cnt_b", 32'(ib.Stall_Cnt), 32'(mb.stall));
      chk("flush_cnt_b", 32'(ib.Flush_Cnt), 32'(mb.flush));
      chk("timeout_b",   32'(ib.Mem_Timeout), 32'(mb.tmo));
      @(negedge clk);
   endtask

   task automatic run(input in_t v);
      apply(v, 1'b0, 1'b0, 7'b0);
   endtask

   task automatic do_reset();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 7'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      in_t  z, lu5, br1, bz1;

      z   = mk(0, 0, 0, 0, 0, 0, 0, 0);
      lu5 = mk(1, 5, 5, 0, 1, 0, 0, 0);
      br1 = mk(0, 0, 0, 0, 0, 0, 1, 0);
      bz1 = mk(0, 0, 0, 0, 0, 0, 0, 1);
      cur = z;
      ma = '{lat: 3, lim: 8, cmax: 65535, bub: 0, busy: 0, stall: 0, flush: 0, tmo: 0};
      mb = '{lat: 1, lim: 1, cmax: 7,     bub: 0, busy: 0, stall: 0, flush: 0, tmo: 0};

      // Decode table, judged on the LOAD_LAT=1 instance which always sits in RUN.
      tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0), O_DEF});
      tbl.push_back('{mk(1, 5, 5, 0, 1, 0, 0, 0), O_STL});
      tbl.push_back('{mk(1, 0, 0, 0, 1, 1, 0, 0), O_DEF});
      tbl.push_back('{mk(1, 5, 5, 5, 0, 0, 0, 0), O_DEF});
      tbl.push_back('{mk(1, 7, 1, 7, 1, 1, 0, 0), O_STL});
      tbl.push_back('{mk(1, 7, 1, 7, 1, 0, 0, 0), O_DEF});
      tbl.push_back('{mk(0, 5, 5, 5, 1, 1, 0, 0), O_DEF});
      tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 0), O_BR});
      tbl.push_back('{mk(1, 9, 9, 0, 1, 0, 1, 0), O_BR});
      tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ});
      tbl.push_back('{mk(1, 9, 9, 0, 1, 0, 1, 1), O_FRZ});
      tbl.push_back('{mk(1, 31, 31, 31, 1, 1, 0, 0), O_STL});

      @(negedge clk);
      #2;
      chk("reset_ctrl_a", 32'(outs_a()), 32'(O_RST));
      chk("reset_ctrl_b", 32'(outs_b()), 32'(O_RST));
      chk("reset_stall_a", 32'(ia.Stall_Cnt), 32'd0);
      chk("reset_timeout_a", 32'(ia.Mem_Timeout), 32'd0);
      @(negedge clk);
      do_reset();

      foreach (tbl[i]) apply(tbl[i].v, 1'b0, 1'b1, tbl[i].exp);

      // LOAD_LAT=3: exactly three bubbles from one load-use hit.
      do_reset();
      run(lu5); run(z); run(z); run(z);
      chk("lat3_stall_cnt", 32'(ia.Stall_Cnt), 32'd3);
      chk("lat1_stall_cnt", 32'(ib.Stall_Cnt), 32'd1);

      // Branch in the second bubble aborts the stall.
      do_reset();
      run(lu5); run(z); run(br1); run(z);
      chk("abort_stall_cnt", 32'(ia.Stall_Cnt), 32'd2);
      chk("abort_flush_cnt", 32'(ia.Flush_Cnt), 32'd1);

      // Freeze mid-stall, then the bubble count resumes.
      do_reset();
      run(lu5); run(bz1); run(bz1); run(bz1); run(bz1); run(z); run(z); run(z);
      chk("freeze_stall_cnt", 32'(ia.Stall_Cnt), 32'd7);
      chk("freeze_no_timeout", 32'(ia.Mem_Timeout), 32'd0);

      // Branch held under busy takes effect on the first non-busy cycle.
      do_reset();
      run(lu5); run(mk(0, 0, 0, 0, 0, 0, 1, 1)); run(mk(0, 0, 0, 0, 0, 0, 1, 1)); run(br1); run(z);
      chk("busy_br_flush_cnt", 32'(ia.Flush_Cnt), 32'd1);

      // Timeout after the eighth consecutive busy edge; sticky until reset.
      do_reset();
      for (int i = 0; i < 7; i++) run(bz1);
      chk("timeout_pre", 32'(ia.Mem_Timeout), 32'd0);
      run(bz1);
      chk("timeout_set", 32'(ia.Mem_Timeout), 32'd1);
      run(z); run(z);
      chk("timeout_sticky", 32'(ia.Mem_Timeout), 32'd1);
      do_reset();
      chk("timeout_cleared", 32'(ia.Mem_Timeout), 32'd0);

      // Asynchronous reset mid LOAD_STALL.
      run(lu5);
      cur = z;
      #3 rst = 1'b1;
      #1;
      chk("async_rst_ctrl", 32'(outs_a()), 32'(O_RST));
      chk("async_rst_stall", 32'(ia.Stall_Cnt), 32'd0);
      @(negedge clk);
      ma = mstep(ma, z, 1'b1);
      mb = mstep(mb, z, 1'b1);
      run(z); run(z);
      chk("post_rst_default", 32'(outs_a()), 32'(O_DEF));

      // Randomized traffic with occasional long busy bursts and rare resets.
      do_reset();
      begin
         int burst = 0;
         for (int i = 0; i < 600; i++) begin
            in_t v;
            logic r;
            v = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            if (burst == 0 && $urandom_range(0, 40) == 0) burst = $urandom_range(6, 12);
            if (burst > 0) begin
               v.busy = 1'b1;
               burst--;
            end
            r = ($urandom_range(0, 149) == 0);
            apply(v, r, 1'b0, 7'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
